// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared states, BCD digit type, digit limits and increment helper
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_UNITS_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;
    localparam bcd_t MIN_UNITS_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX  = 4'd5;

    function automatic bcd_t bcd_next(bcd_t v, logic inc, logic clr, bcd_t max);
        return clr ? bcd_t'(0) : (inc ? ((v == max) ? bcd_t'(0) : v + 4'd1) : v);
    endfunction

endpackage

// File: rtl/stopwatch_controller_digit.sv
// bcd_digit_counter: one BCD digit that wraps at MAX and emits a carry on wrap
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output bcd_t value,
    output logic carry_out
);

    assign carry_out = inc && (value == MAX);

    // advance, wrap or clear the digit
    always_ff @(posedge clk) begin
        value <= rst ? bcd_t'(0) : bcd_next(value, inc, clr, MAX);
    end

endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: 1 s time base, run/pause/lap/clear FSM and MM:SS display registers
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] units_second,
    output logic [3:0] tens_second,
    output logic [3:0] units_minute,
    output logic [3:0] tens_minute,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_t        state, next_state;
    logic [PW-1:0] presc;
    logic          counting, sec_tick, do_clear;
    logic [3:0]    carry;
    bcd_t          us_live, ts_live, um_live, tm_live;
    bcd_t          us_nxt, ts_nxt, um_nxt, tm_nxt;

    assign counting = (state == RUN) || (state == LAP);
    assign sec_tick = counting && (presc == LAST);
    assign do_clear = (state == PAUSE) && clear && !start_stop;

    bcd_digit_counter #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clk(clk), .rst(rst), .inc(sec_tick), .clr(do_clear), .value(us_live), .carry_out(carry[0])
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .inc(carry[0]), .clr(do_clear), .value(ts_live), .carry_out(carry[1])
    );
    bcd_digit_counter #(.MAX(MIN_UNITS_MAX)) u_min_units (
        .clk(clk), .rst(rst), .inc(carry[1]), .clr(do_clear), .value(um_live), .carry_out(carry[2])
    );
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .inc(carry[2]), .clr(do_clear), .value(tm_live), .carry_out(carry[3])
    );

    // post-edge live count, so the display can follow it without a cycle of lag
    assign us_nxt = bcd_next(us_live, sec_tick, do_clear, SEC_UNITS_MAX);
    assign ts_nxt = bcd_next(ts_live, carry[0], do_clear, SEC_TENS_MAX);
    assign um_nxt = bcd_next(um_live, carry[1], do_clear, MIN_UNITS_MAX);
    assign tm_nxt = bcd_next(tm_live, carry[2], do_clear, MIN_TENS_MAX);

    // next state; start_stop always wins, otherwise the first legal of clear/lap
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = start_stop ? RUN : IDLE;
            RUN:     next_state = start_stop ? PAUSE : (lap ? LAP : RUN);
            LAP:     next_state = start_stop ? PAUSE : (lap ? RUN : LAP);
            PAUSE:   next_state = start_stop ? RUN : (clear ? IDLE : PAUSE);
            default: next_state = IDLE;
        endcase
    end

    // state register and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= next_state;
            running    <= (next_state == RUN) || (next_state == LAP);
            lap_active <= next_state == LAP;
            overflow   <= carry[3];
        end
    end

    // prescaler runs while counting, holds in PAUSE so the sub-second phase survives
    always_ff @(posedge clk) begin
        if (rst || do_clear || state == IDLE)
            presc <= '0;
        else if (counting)
            presc <= sec_tick ? '0 : presc + 1'b1;
    end

    // display follows the live count except while staying in LAP
    always_ff @(posedge clk) begin
        if (rst) begin
            {tens_minute, units_minute, tens_second, units_second} <= '0;
        end else if (!(state == LAP && next_state == LAP)) begin
            {tens_minute, units_minute, tens_second, units_second} <= {tm_nxt, um_nxt, ts_nxt, us_nxt};
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed plan plus random commands against a seconds-level model
module tb_stopwatch_controller;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    logic clk = 0, rst = 1, start_stop = 0, lap = 0, clear = 0;
    logic [3:0] units_second, tens_second, units_minute, tens_minute;
    logic running, lap_active, overflow;

    int compared = 0, mismatched = 0;

    stopwatch_controller #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
        .units_second(units_second), .tens_second(tens_second),
        .units_minute(units_minute), .tens_minute(tens_minute),
        .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int  m_mode = M_IDLE, m_secs = 0, m_phase = 0, m_disp = 0;
    bit  m_ovf = 0, m_ok = 0;

    // behavioural model: elapsed time in whole seconds plus sub-second phase
    always @(posedge clk) begin
        int prev;
        bit tick, cnt;
        if (rst) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_disp = 0; m_ovf = 0;
        end else begin
            cnt   = (m_mode == M_RUN) || (m_mode == M_LAP);
            tick  = cnt && (m_phase == TD - 1);
            m_ovf = tick && (m_secs == 3599);
            if (cnt) m_phase = tick ? 0 : m_phase + 1;
            if (tick) m_secs = (m_secs + 1) % 3600;
            prev = m_mode;
            if (start_stop) m_mode = cnt ? M_PAUSE : M_RUN;
            else if (clear && m_mode == M_PAUSE) begin
                m_mode = M_IDLE; m_secs = 0; m_phase = 0;
            end else if (lap && m_mode == M_RUN) m_mode = M_LAP;
            else if (lap && m_mode == M_LAP) m_mode = M_RUN;
            if (!(prev == M_LAP && m_mode == M_LAP)) m_disp = m_secs;
        end
        m_ok = 1;
    end

    function automatic logic [15:0] to_bcd(int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    // every-cycle comparison against the model
    always @(negedge clk) begin
        logic [18:0] exp_v, act_v;
        if (m_ok) begin
            exp_v = {to_bcd(m_disp), (m_mode == M_RUN) || (m_mode == M_LAP), m_mode == M_LAP, m_ovf};
            act_v = {tens_minute, units_minute, tens_second, units_second, running, lap_active, overflow};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL model t=%0t got disp=%h run=%b lap=%b ovf=%b expected disp=%h run=%b lap=%b ovf=%b",
                         $time, act_v[18:3], act_v[2], act_v[1], act_v[0],
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int disp();
        return int'({tens_minute, units_minute, tens_second, units_second});
    endfunction

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(logic s, logic l, logic c);
        start_stop = s; lap = l; clear = c;
        @(posedge clk); #1;
        start_stop = 0; lap = 0; clear = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        wait_cycles(1);
        rst = 0;
    endtask

    initial begin
        // reset with start_stop held high
        start_stop = 1;
        wait_cycles(3);
        start_stop = 0; rst = 0;
        chk("reset_disp", disp(), 0);
        chk("reset_running", running, 0);
        chk("reset_lap", lap_active, 0);
        chk("reset_ovf", overflow, 0);
        wait_cycles(2);
        chk("idle_after_reset", running, 0);

        // counting and wrap
        pulse(1, 0, 0);
        chk("start_running", running, 1);
        wait_cycles(3);
        chk("pre_first_tick", disp(), 16'h0000);
        wait_cycles(1);
        chk("first_tick", disp(), 16'h0001);
        wait_cycles(236);
        chk("one_minute", disp(), 16'h0100);
        wait_cycles(14400 - 240 - 1);
        chk("pre_wrap", disp(), 16'h5959);
        chk("pre_wrap_ovf", overflow, 0);
        wait_cycles(1);
        chk("wrap_disp", disp(), 16'h0000);
        chk("wrap_ovf", overflow, 1);
        chk("wrap_running", running, 1);
        wait_cycles(1);
        chk("ovf_one_cycle", overflow, 0);

        // lap freeze and release
        do_reset();
        pulse(1, 0, 0);
        wait_cycles(28);
        chk("at_7", disp(), 16'h0007);
        pulse(0, 1, 0);
        chk("lap_hold", disp(), 16'h0007);
        chk("lap_active", lap_active, 1);
        wait_cycles(19);
        chk("lap_frozen", disp(), 16'h0007);
        pulse(0, 1, 0);
        chk("lap_release", disp(), 16'h0012);
        chk("lap_off", lap_active, 0);

        // pause mid-second, resume keeps phase, clear rules
        do_reset();
        pulse(1, 0, 0);
        wait_cycles(9);
        pulse(1, 0, 0);
        chk("paused", running, 0);
        wait_cycles(50);
        chk("pause_hold", disp(), 16'h0002);
        pulse(1, 0, 0);
        wait_cycles(1);
        chk("resume_before", disp(), 16'h0002);
        wait_cycles(1);
        chk("resume_tick", disp(), 16'h0003);
        pulse(0, 0, 1);
        chk("clear_in_run", running, 1);
        chk("clear_in_run_disp", disp(), 16'h0003);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("clear_pause_disp", disp(), 16'h0000);
        chk("clear_pause_run", running, 0);

        // priority and reset in LAP
        pulse(1, 0, 0);
        wait_cycles(5);
        pulse(1, 1, 0);
        chk("prio_running", running, 0);
        chk("prio_lap", lap_active, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("relap", lap_active, 1);
        wait_cycles(6);
        do_reset();
        chk("rst_lap_disp", disp(), 0);
        chk("rst_lap_state", lap_active, 0);
        chk("rst_lap_run", running, 0);

        // random command traffic
        for (int i = 0; i < 4000; i++) begin
            start_stop = $urandom_range(0, 11) == 0;
            lap        = $urandom_range(0, 7) == 0;
            clear      = $urandom_range(0, 5) == 0;
            rst        = $urandom_range(0, 599) == 0;
            wait_cycles(1);
        end
        start_stop = 0; lap = 0; clear = 0; rst = 0;
        wait_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the MM:SS display path. Divides the system clock into a 1 s time base and runs a start/stop/lap/clear state machine. Maintains four BCD digit registers, wrapping from 59:59 to 00:00. Its digit outputs drive the display handler directly: each 4-bit digit is split there into per-digit a/b/c/d lines.

## Interface
- TICK_DIV, default 100_000_000: clock cycles per second; legal range 2 to 2^27.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- start_stop  in  1  single-cycle command pulse; toggles run/pause.
- lap  in  1  single-cycle command pulse; freezes or unfreezes the displayed value.
- clear  in  1  single-cycle command pulse; zeroes the time.
- units_second  out  4  displayed seconds units, BCD 0-9.
- tens_second  out  4  displayed seconds tens, BCD 0-5.
- units_minute  out  4  displayed minutes units, BCD 0-9.
- tens_minute  out  4  displayed minutes tens, BCD 0-5.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  one-cycle pulse when the count wraps 59:59 -> 00:00.

## Operation
- States:
  - IDLE: stopped at 00:00.
  - RUN: counting; display shows the live count.
  - PAUSE: stopped; display shows the live count.
  - LAP: counting; display frozen.
- Transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - RUN --lap--> LAP; the live count is captured into the display registers.
  - LAP --lap--> RUN; the display returns to the live count.
  - LAP --start_stop--> PAUSE; the display returns to the live count.
  - PAUSE --start_stop--> RUN.
  - PAUSE --clear--> IDLE; the live count and the prescaler are zeroed.
- Ignored commands:
  - clear in RUN, LAP and IDLE.
  - lap in IDLE and PAUSE.
- Simultaneous commands: priority is start_stop > clear > lap. Only the highest-priority legal command acts; the others are dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in RUN or LAP.
  - Holds its value in PAUSE, so the sub-second phase is preserved on resume.
  - Zeroed in IDLE.
  - sec_tick is asserted in the cycle where the prescaler equals TICK_DIV-1 and the state is RUN or LAP.
- Live count:
  - On sec_tick, units_second increments.
  - Each digit wraps at its maximum (9, 5, 9, 5) and carries into the next digit.
  - 59:59 + 1 = 00:00, with an overflow pulse. The state is unchanged; counting continues.
- Display registers:
  - Track the live count every cycle in RUN, PAUSE and IDLE.
  - Hold the captured value in LAP.
- All outputs are registered. Digits never leave the BCD range.

## Timing
- Reset: state = IDLE, prescaler = 0, all digits = 0, running = 0, lap_active = 0, overflow = 0.
- rst takes priority over every command, including in mid-count and in LAP.
- Command latency: a command sampled at edge N changes the state at edge N. running and lap_active are visible after edge N.
- First tick: with start_stop at edge 0, the first sec_tick falls in the cycle following edge TICK_DIV-1. units_second = 1 is visible after edge TICK_DIV.
- Digit update: the digits update on the edge that samples sec_tick. overflow is high for exactly the following cycle.
- Lap capture: the display freezes at the live value from the lap edge onward.
- start_stop coinciding with sec_tick in RUN: the tick is counted and the state moves to PAUSE. The prescaler wraps to 0 and holds there.

## Structure
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE, LAP}.
  - Constants SEC_UNITS_MAX = 9, SEC_TENS_MAX = 5, MIN_UNITS_MAX = 9, MIN_TENS_MAX = 5.
  - BCD digit typedef, 4 bits.
- Sub-module bcd_digit_counter:
  - Parameter MAX.
  - Ports: inc, sync clear, value, carry_out (combinational, high when inc && value == MAX).
  - Instantiated four times and chained through carry.
- The top level contains the FSM, the prescaler and the display/lap registers.

## Test plan
All tests use TICK_DIV = 4.
1. Reset: assert rst for 3 cycles -> all digits 0, running = 0, lap_active = 0, overflow = 0. Issue start_stop while rst is high -> stays IDLE.
2. Counting: start_stop, then run 240 cycles -> display shows 01:00 (tens_minute = 0, units_minute = 1, tens_second = 0, units_second = 0). The first increment is visible after edge 4.
3. Wrap: run 14400 cycles from start -> display 00:00. overflow high for exactly one cycle. running stays 1.
4. Lap:
   - Issue lap at 00:07 -> display holds 00:07 and lap_active = 1.
   - After 20 more cycles, issue lap -> display shows 00:12.
5. Pause/resume:
   - Pause 2 cycles into a second; wait 50 cycles with the display fixed; resume -> next increment after 2 cycles.
   - clear in RUN is ignored.
   - clear in PAUSE -> IDLE and 00:00.
6. Priority and reset: start_stop and lap together in RUN -> PAUSE, lap_active = 0. rst during LAP -> IDLE, 00:00.
